i2c_bus_monitor: RTL

//   Front-end conditioner for the I2C slave. Synchronizes and de-glitches the
//   raw scl/sda pad lines and detects START, STOP and SCL edges. Shifts in each

---
 rtl/i2c_bus_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/i2c_bus_monitor.sv
// I2C bus front end: synchronizes and de-glitches SCL/SDA, detects bus
// conditions and SCL edges, and delivers received bytes and ACK bits as strobes.
module i2c_bus_monitor #(
   parameter int FILTER_LEN = 3
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic       i_scl_in,
   input  logic       i_sda_in,
   output logic       o_scl_f,
   output logic       o_sda_f,
   output logic       o_scl_rise,
   output logic       o_scl_fall,
   output logic       o_start_det,
   output logic       o_stop_det,
   output logic       o_bus_busy,
   output logic       o_byte_done,
   output logic [7:0] o_byte_data,
   output logic       o_ack_strobe,
   output logic       o_ack_value
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   // Bit 0 carries SCL, bit 1 carries SDA through the sync/filter pipeline.
   logic [1:0]         w_pad;
   logic [1:0]         r_sync1, r_sync2, r_filt, r_prev;
   logic [1:0][CW-1:0] r_cnt;

   logic w_scl_rise, w_scl_fall, w_scl_hi, w_start, w_stop;

   logic       r_scl_rise, r_scl_fall, r_start, r_stop, r_busy;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shreg, r_byte_data;
   logic       r_byte_pend, r_byte_done;
   logic       r_ack_pend, r_ack_smp, r_ack_strobe, r_ack_value;

   assign w_pad = {i_sda_in, i_scl_in};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_filt  <= '1;
         r_prev  <= '1;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= w_pad;
         r_sync2 <= r_sync1;
         r_prev  <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
               r_filt[i] <= r_sync2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // A simultaneous SCL and SDA change fails w_scl_hi, so it never forms START/STOP.
   assign w_scl_rise = r_filt[0] & ~r_prev[0];
   assign w_scl_fall = ~r_filt[0] & r_prev[0];
   assign w_scl_hi   = r_filt[0] & r_prev[0];
   assign w_start    = w_scl_hi & r_prev[1] & ~r_filt[1];
   assign w_stop     = w_scl_hi & ~r_prev[1] & r_filt[1];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_scl_rise   <= 1'b0;
         r_scl_fall   <= 1'b0;
         r_start      <= 1'b0;
         r_stop       <= 1'b0;
         r_busy       <= 1'b0;
         r_bit_cnt    <= '0;
         r_shreg      <= '0;
         r_byte_pend  <= 1'b0;
         r_byte_done  <= 1'b0;
         r_byte_data  <= 8'h00;
         r_ack_pend   <= 1'b0;
         r_ack_smp    <= 1'b1;
         r_ack_strobe <= 1'b0;
         r_ack_value  <= 1'b1;
      end else if (!i_en) begin
         r_scl_rise   <= 1'b0;
         r_scl_fall   <= 1'b0;
         r_start      <= 1'b0;
         r_stop       <= 1'b0;
         r_busy       <= 1'b0;
         r_bit_cnt    <= '0;
         r_shreg      <= '0;
         r_byte_pend  <= 1'b0;
         r_byte_done  <= 1'b0;
         r_ack_pend   <= 1'b0;
         r_ack_strobe <= 1'b0;
      end else begin
         r_scl_rise   <= w_scl_rise;
         r_scl_fall   <= w_scl_fall;
         r_start      <= w_start;
         r_stop       <= w_stop;
         r_byte_done  <= r_byte_pend;
         r_ack_strobe <= r_ack_pend;
         r_byte_pend  <= 1'b0;
         r_ack_pend   <= 1'b0;
         if (r_byte_pend) r_byte_data <= r_shreg;
         if (r_ack_pend)  r_ack_value <= r_ack_smp;

         if (w_start)     r_busy <= 1'b1;
         else if (w_stop) r_busy <= 1'b0;

         // Bytes are framed from the most recent START; bit 9 of each frame is ACK.
         if (w_start || w_stop) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
         end else if (r_busy && w_scl_rise) begin
            if (r_bit_cnt == 4'd8) begin
               r_ack_smp  <= r_filt[1];
               r_ack_pend <= 1'b1;
               r_bit_cnt  <= '0;
            end else begin
               r_shreg   <= {r_shreg[6:0], r_filt[1]};
               r_bit_cnt <= r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) r_byte_pend <= 1'b1;
            end
         end
      end
   end

   assign o_scl_f      = r_filt[0];
   assign o_sda_f      = r_filt[1];
   assign o_scl_rise   = r_scl_rise;
   assign o_scl_fall   = r_scl_fall;
   assign o_start_det  = r_start;
   assign o_stop_det   = r_stop;
   assign o_bus_busy   = r_busy;
   assign o_byte_done  = r_byte_done;
   assign o_byte_data  = r_byte_data;
   assign o_ack_strobe = r_ack_strobe;
   assign o_ack_value  = r_ack_value;
endmodule
